// File: rtl/comm_pkg.sv
// Shared constants for the BPSK loopback link: default timing, accumulator width, reset levels.
// The optional differential coding is selected with the DIFF_ENC_EN macro.
package comm_pkg;

    localparam int SAMPLES_PER_BIT_DEF = 16;
    localparam int CARRIER_HALF_DEF    = 2;

    // Wide enough to hold a full window of matches (0..SAMPLES_PER_BIT).
    localparam int ACC_W = $clog2(SAMPLES_PER_BIT_DEF + 1);

    localparam logic RST_ACTIVE   = 1'b0;
    localparam logic RST_INACTIVE = 1'b1;

endpackage

// File: rtl/bpsk_receiver.sv
// Coherent BPSK correlator: registers the LO, counts channel/LO agreement over one bit window
// and takes a strict-majority decision. DIFF_ENC_EN adds differential decoding of the decisions.
module bpsk_receiver
    import comm_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEF,
    parameter int BCNT_W          = $clog2(SAMPLES_PER_BIT)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              lo_i,
    input  logic              channel_i,
    input  logic [BCNT_W-1:0] bcnt_i,
    output logic              data_o
);

    localparam int ACC_W_L = $clog2(SAMPLES_PER_BIT + 1);

    logic               lo_q;
    logic [BCNT_W-1:0]  bcnt_dly_q;
    logic [ACC_W_L-1:0] acc_q, acc_d;
    logic               data_q, data_d;
    logic               prev_dec_q, prev_dec_d;
    logic               match;
    logic               boundary;
    logic               decision;

    // channel_i and lo_q both trail bcnt_i by two registers, so the first sample of a bit
    // arrives while the one-cycle-delayed count reads 1; that cycle opens the next window.
    assign match    = channel_i ~^ lo_q;
    assign boundary = (bcnt_dly_q == BCNT_W'(1));
    assign decision = (acc_q > ACC_W_L'(SAMPLES_PER_BIT / 2));

    always_comb begin
        acc_d      = acc_q + ACC_W_L'(match);
        data_d     = data_q;
        prev_dec_d = prev_dec_q;
        if (boundary) begin
            acc_d      = ACC_W_L'(match);
            prev_dec_d = decision;
`ifdef DIFF_ENC_EN
            data_d     = decision ^ prev_dec_q;
`else
            data_d     = decision;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni == RST_ACTIVE) begin
            lo_q       <= 1'b0;
            bcnt_dly_q <= '0;
            acc_q      <= '0;
            data_q     <= 1'b0;
            prev_dec_q <= 1'b0;
        end else begin
            lo_q       <= lo_i;
            bcnt_dly_q <= bcnt_i;
            acc_q      <= acc_d;
            data_q     <= data_d;
            prev_dec_q <= prev_dec_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/comm_system.sv
// BPSK loopback top: bit counter, square-wave carrier, transmitter and the bpsk_receiver.
// Defining DIFF_ENC_EN switches both ends to differential coding (tolerates an inverted LO).
module comm_system
    import comm_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEF,
    parameter int CARRIER_HALF    = CARRIER_HALF_DEF
) (
    input  logic transmitter_clk,
    input  logic transmitter_rst,
    input  logic transmitter_data_i,
    input  logic receiver_LO,
    output logic receiver_data_o,
    output logic channel_o
);

    localparam int BCNT_W = $clog2(SAMPLES_PER_BIT);
    localparam int CCNT_W = (2 * CARRIER_HALF > 1) ? $clog2(2 * CARRIER_HALF) : 1;

    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [CCNT_W-1:0] ccnt_q, ccnt_d;
    logic              tx_bit_q, tx_bit_d;
    logic              channel_q, channel_d;
    logic              carrier;
    logic              tx_next;

    // Carrier is high for the first half of each period, so it reads 1 right after reset.
    assign carrier = (ccnt_q < CCNT_W'(CARRIER_HALF));

`ifdef DIFF_ENC_EN
    assign tx_next = transmitter_data_i ^ tx_bit_q;
`else
    assign tx_next = transmitter_data_i;
`endif

    always_comb begin
        bcnt_d    = bcnt_q + BCNT_W'(1);
        ccnt_d    = ccnt_q + CCNT_W'(1);
        tx_bit_d  = tx_bit_q;
        channel_d = carrier ~^ tx_bit_q;
        if (bcnt_q == BCNT_W'(SAMPLES_PER_BIT - 1)) begin
            bcnt_d = '0;
        end
        if (ccnt_q == CCNT_W'(2 * CARRIER_HALF - 1)) begin
            ccnt_d = '0;
        end
        if (bcnt_q == '0) begin
            tx_bit_d = tx_next;
        end
    end

    always_ff @(posedge transmitter_clk) begin
        if (transmitter_rst == RST_ACTIVE) begin
            bcnt_q    <= '0;
            ccnt_q    <= '0;
            tx_bit_q  <= 1'b0;
            channel_q <= 1'b0;
        end else begin
            bcnt_q    <= bcnt_d;
            ccnt_q    <= ccnt_d;
            tx_bit_q  <= tx_bit_d;
            channel_q <= channel_d;
        end
    end

    assign channel_o = channel_q;

    bpsk_receiver #(
        .SAMPLES_PER_BIT (SAMPLES_PER_BIT),
        .BCNT_W          (BCNT_W)
    ) u_rx (
        .clk_i     (transmitter_clk),
        .rst_ni    (transmitter_rst),
        .lo_i      (receiver_LO),
        .channel_i (channel_q),
        .bcnt_i    (bcnt_q),
        .data_o    (receiver_data_o)
    );

endmodule

// File: tb/tb_comm_system.sv
// Bench for comm_system: per-bit reference model feeds an expected queue, a monitor compares
// each recovered bit at the start and end of its hold interval. Honours DIFF_ENC_EN.
module tb_comm_system;

    localparam int SPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic data_i = 1'b0;
    logic lo = 1'b0;
    logic rx_data;
    logic channel;

    int   lo_mode = 0;      // 0 in phase, 1 inverted, 2 delayed one clock
    int   edge_idx = -1;    // index of the last clock edge since reset release
    logic exp_q[$];
    logic m_t = 1'b0;       // model: bit currently being transmitted
    logic m_dec = 1'b0;     // model: previous raw decision
    logic cur_exp = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    logic pattern [17] = '{1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};

    comm_system dut (
        .transmitter_clk    (clk),
        .transmitter_rst    (rst),
        .transmitter_data_i (data_i),
        .receiver_LO        (lo),
        .receiver_data_o    (rx_data),
        .channel_o          (channel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp, input int idx);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %b expected %b", name, idx, act, exp);
    endtask

    function automatic logic carrier_at(input int c);
        return ((((c % 4) + 4) % 4) < 2);
    endfunction

    // Reference model: one expected output bit per transmitted data bit.
    always @(posedge clk) begin
        logic dec;
        if (!rst) begin
            edge_idx = -1;
            exp_q.delete();
            m_t   = 1'b0;
            m_dec = 1'b0;
        end else begin
            edge_idx = edge_idx + 1;
            if (edge_idx == 0) exp_q.push_back(1'b0);  // window cut by reset release
            if (edge_idx % SPB == 0) begin
`ifdef DIFF_ENC_EN
                m_t = data_i ^ m_t;
`else
                m_t = data_i;
`endif
                case (lo_mode)
                    0:       dec = m_t;
                    1:       dec = ~m_t;
                    default: dec = 1'b0;
                endcase
`ifdef DIFF_ENC_EN
                exp_q.push_back(dec ^ m_dec);
                m_dec = dec;
`else
                exp_q.push_back(dec);
`endif
            end
        end
    end

    // Monitor: a decision lands 18 edges after its sample edge and holds 16 clocks.
    always @(posedge clk) begin
        #1;
        if (rst && edge_idx >= 2) begin
            if ((edge_idx - 2) % SPB == 0) begin
                if (exp_q.size() == 0) begin
                    check("rx_data_queue_empty", 1'b1, 1'b0, edge_idx);
                end else begin
                    cur_exp = exp_q.pop_front();
                    check("rx_data_start", rx_data, cur_exp, edge_idx);
                end
            end else if ((edge_idx - 2) % SPB == SPB - 1) begin
                check("rx_data_hold", rx_data, cur_exp, edge_idx);
            end
        end
        if (rst && edge_idx >= 1 && edge_idx % SPB != 0 && edge_idx % 5 == 0) begin
            check("channel", channel, carrier_at(edge_idx) ~^ m_t, edge_idx);
        end
    end

    // Local oscillator derived from the cycle number since release.
    always @(negedge clk) begin
        int c;
        c = edge_idx + 1;
        case (lo_mode)
            0:       lo = carrier_at(c);
            1:       lo = ~carrier_at(c);
            default: lo = carrier_at(c - 1);
        endcase
    end

    task automatic do_reset(input int n, input int mode);
        @(negedge clk);
        rst = 1'b0;
        lo_mode = mode;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("reset_rx_data", rx_data, 1'b0, edge_idx);
            check("reset_channel", channel, 1'b0, edge_idx);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives b onto data_i for the next sample edge; in between, optional random noise.
    task automatic send_bit(input logic b, input bit noise);
        for (int i = 0; i < 2 * SPB; i++) begin
            @(negedge clk);
            if ((edge_idx + 1) % SPB == 0) begin
                data_i = b;
                break;
            end
            data_i = noise ? 1'($urandom_range(0, 1)) : b;
        end
    endtask

    task automatic send_pattern(input int reps, input bit noise);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < 17; i++) send_bit(pattern[i], noise);
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), 1'b1);
    endtask

    initial begin
        do_reset(4, 0);

        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
        send_pattern(3, 1'b0);
        send_random(8);

        for (int i = 0; i < SPB; i++) begin
            if (edge_idx % SPB == 7) break;
            @(negedge clk);
        end
        do_reset(5, 0);
        send_pattern(1, 1'b1);
        send_random(3);

        do_reset(3, 1);
        send_pattern(2, 1'b1);
        send_random(3);

        do_reset(3, 2);
        send_random(6);

        do_reset(3, 0);
        send_pattern(1, 1'b1);
        send_random(3);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/comm_system.md
# comm_system

Single-clock digital BPSK link: a transmitter modulates a serial bit stream onto a square-wave carrier, and a receiver coherently demodulates it against an externally supplied local-oscillator square wave. It returns the recovered bit stream. This is the top-level loopback block used to validate the modem chain; the modulated wave passes straight from transmitter to receiver inside the block.

## Interface
- SAMPLES_PER_BIT, 16: clocks per data bit; must be an even multiple of 2*CARRIER_HALF.
- CARRIER_HALF, 2: clocks per carrier half-period.
- transmitter_clk  in  1  single system clock; receiver shares it.
- transmitter_rst  in  1  reset, synchronous, active-low; resets transmitter and receiver together.
- transmitter_data_i  in  1  serial data bit, synchronous to transmitter_clk.
- receiver_LO  in  1  local-oscillator square wave, same frequency as the carrier, sampled as data.
- receiver_data_o  out  1  recovered data bit.
- channel_o  out  1  modulated transmitter wave, for observation.

## Operation
- Bit counter `bcnt` runs 0..SAMPLES_PER_BIT-1 and wraps. Both halves share it.
- Carrier generator:
  - Counter toggles `carrier` every CARRIER_HALF clocks.
  - `carrier` is 1 in the first cycle after reset release.
- Transmitter:
  - When bcnt==0, latch transmitter_data_i into `tx_bit`.
  - channel_o is registered: `carrier` if tx_bit=1, `~carrier` if tx_bit=0 (XNOR).
- Receiver:
  - Register receiver_LO once into `lo_q`, so it aligns with registered channel_o.
  - Each cycle compute `match = channel_o XNOR lo_q`.
  - Accumulator `acc` (width clog2(SAMPLES_PER_BIT+1)) counts matches over one window.
  - The window is bcnt delayed by one cycle.
  - At window end: receiver_data_o <= (acc > SAMPLES_PER_BIT/2), then acc restarts from the current cycle's match.
  - Tie (acc == SAMPLES_PER_BIT/2) decides 0.
- LO phase requirements:
  - Coherent detection requires receiver_LO in phase with the carrier.
  - At 180° offset the output is inverted; see DIFF_ENC_EN.
  - At 90° offset the output is undefined; this is not a supported operating point.

## Timing
- Reset values: receiver_data_o=0, channel_o=0, tx_bit=0, acc=0, bcnt=0, carrier counter=0.
- The cycle after reset deasserts is bcnt=0, and transmitter_data_i is sampled on that edge.
- Latency: a bit sampled at bcnt==0 appears on receiver_data_o exactly SAMPLES_PER_BIT+2 clocks later and holds for SAMPLES_PER_BIT clocks.
- transmitter_data_i changes between sample points are ignored; only the value at bcnt==0 matters.
- Reset mid-operation: everything returns to reset values on the next edge, and any partial window is discarded.
  - The carrier phase restarts, so the LO source must restart aligned.
- No handshake. Output is a continuous bit stream; the first valid bit follows the latency above.
  - The window in progress at reset release produces 0.

## Configuration
- DIFF_ENC_EN defined:
  - Transmitter sends `tx_bit = data XOR prev_tx_bit`.
  - Receiver outputs `decision XOR prev_decision`.
  - Both previous-bit registers reset to 0.
  - Output is correct with LO inverted (180°).
  - Latency is unchanged, but the first output bit after reset may be wrong.
- DIFF_ENC_EN undefined: plain coherent BPSK as above. An inverted LO yields an inverted output.

## Structure
- Package `comm_pkg` holds:
  - default SAMPLES_PER_BIT and CARRIER_HALF;
  - derived ACC_W = clog2(SAMPLES_PER_BIT+1);
  - reset-level constants (active low).
- One natural sub-module: `bpsk_receiver` (LO register, correlator, accumulator, decision, optional differential decode).
- Transmitter, carrier generator and bit counter stay in the top.

## Test plan
All scenarios use defaults (16, 2). LO starts at 1 in the first cycle after reset release and toggles every 2 clocks.
- Hold data_i=1 → channel_o equals the carrier. From cycle 18 after release, receiver_data_o=1 (acc=16 each window).
- Repeating pattern 1,1,0,1,0,0,1,1,0,0,0,1,1,1,0,0,0, one bit per 16 clocks → same sequence on receiver_data_o, delayed 18 clocks, zero errors over 3 repetitions.
- Reset asserted for 5 clocks mid-bit, then released → all outputs 0 while in reset. The pattern recovers with the same 18-clock latency from release.
- LO inverted, DIFF_ENC_EN undefined → receiver_data_o is the bitwise complement of the pattern.
  - Same stimulus with DIFF_ENC_EN defined → correct pattern after the first bit.
- LO delayed by 1 clock (quarter period) → acc=8 each window, receiver_data_o=0 (tie rule).
- Change data_i at bcnt=5 within a bit → the change is not reflected until the next bcnt==0 sample.
